date_programmer: RTL
====================

Name: date_programmer

Overview:
- Producer side of the on-screen date path: owns the BCD day/month/year words and the edit cursor that the VGA date renderer displays and highlights.
- In normal mode it mirrors the RTC date.
- In programming mode it edits the date from push-buttons with BCD wrap rules, then hands the result to the RTC write controller over a req/ack handshake.

Parameters:
- SYNC_STAGES, 2: button synchronizer depth, in flops; legal range is 2 or more.
- REPEAT_CYCLES, 25_000_000: hold time before auto-repeat starts, and the period between repeats.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- programar_on  in  1  programming mode request, level
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous push-buttons, active-high
- rtc_day, rtc_month, rtc_year  in  8 each  packed-BCD date from the RTC reader
- wr_ack  in  1  RTC write controller accepted the date; single-cycle pulse
- fecha_out1  out  8  day, BCD 01..31; goes to renderer fecha_in1
- fecha_out2  out  8  month, BCD 01..12; goes to fecha_in2
- fecha_out3  out  8  year, BCD 00..99; goes to fecha_in3
- direccion_actual_pantalla  out  4  cursor: 0 = none, 3 = day, 4 = month, 5 = year
- wr_req  out  1  date valid for the RTC write; held until wr_ack

Behaviour:
Reset:
- fecha_out1 = 8'h01, fecha_out2 = 8'h01, fecha_out3 = 8'h00.
- direccion_actual_pantalla = 0, wr_req = 0, state = IDLE.
- All synchronizer and repeat counters are cleared.

Button conditioning:
- Each button goes through a SYNC_STAGES flop chain, then a rising-edge detect, producing a 1-cycle pulse.
- If a button is held, an extra pulse is produced each time the hold counter reaches REPEAT_CYCLES-1; the counter then restarts. Release clears the counter.
- Latency: with SYNC_STAGES=2, a button first high before edge N changes the outputs at edge N+2.

State IDLE:
- Every cycle, fecha_out1/2/3 take rtc_day/rtc_month/rtc_year.
- direccion_actual_pantalla = 0. Buttons are ignored.
- When programar_on = 1, go to EDIT. On that same edge, snapshot the RTC inputs into fecha_out and set direccion_actual_pantalla = 3.

State EDIT:
- fecha_out holds its value except when edited.
- right: cursor 3 -> 4 -> 5 -> 3. left: cursor 3 -> 5 -> 4 -> 3.
- up/down act on the field under the cursor, in BCD digit arithmetic:
  - Day: up 31 -> 01, down 01 -> 31.
  - Month: up 12 -> 01, down 01 -> 12.
  - Year: up 99 -> 00, down 00 -> 99.
  - Tens digit carries and borrows correctly, e.g. day 09 up -> 10, day 10 down -> 09.
  - Digits stay within 0..9 at all times.
- up and down pulsing in the same cycle: no value change.
- left and right pulsing in the same cycle: no cursor change.
- A cursor pulse and a value pulse in the same cycle: the value pulse applies to the old cursor field, and the cursor moves on the same edge.
- When programar_on = 0, go to COMMIT. Set wr_req = 1 and direccion_actual_pantalla = 0 on that edge.

State COMMIT:
- fecha_out is frozen and buttons are ignored.
- wr_req stays 1 until a cycle with wr_ack = 1. On that edge: wr_req = 0, go to IDLE.
- If programar_on rises again while in COMMIT, it is ignored until the handshake completes. If it is still high after the return to IDLE, EDIT is re-entered on the next edge.

General:
- wr_ack received outside COMMIT is ignored.
- Reset in any state, including mid-COMMIT with wr_req high, drops wr_req at the next edge; no write is retried.

Optional Feature:
Macro: DATE_PROG_MONTH_DAYS_EN

Defined:
- The day upper bound depends on the current month and year:
  - Months 04, 06, 09, 11: 30.
  - Month 02: 29 if the year is divisible by 4 (BCD year with tens-even/units in {0,4,8}, or tens-odd/units in {2,6}); otherwise 28.
  - All other months: 31.
- Day up wraps from the bound to 01. Day down from 01 goes to the bound.
- Whenever month or year changes in EDIT, or the RTC snapshot is taken, a day above the new bound is clamped to the bound on the same edge.

Undefined:
- The day range is a fixed 01..31 and no clamping occurs.

Test Plan:
- Reset, then reset released with rtc = 15/08/24 in IDLE -> after 1 edge, fecha_out = 8'h15 / 8'h08 / 8'h24, direccion = 0, wr_req = 0.
- programar_on = 1 with rtc = 09/12/99; press up (day), right, up (month), right, up (year) -> day 8'h10, month 8'h01, year 8'h00; direccion sequence 3, 4, 5.
- Cursor at 3 with day 8'h01: down -> 8'h31; left -> direccion 5; up and down pressed on the same cycle -> year unchanged.
- Hold up for 3*REPEAT_CYCLES+10 cycles (REPEAT_CYCLES set to 16 in the bench) with day 8'h28 -> 4 increments total, day = 8'h01 after the 31 wrap.
- programar_on falls -> wr_req = 1 with fecha_out frozen; wr_ack after 5 cycles -> wr_req = 0 on that edge, state back to IDLE mirroring rtc; assert reset during a second COMMIT -> wr_req = 0 the next edge.
- With DATE_PROG_MONTH_DAYS_EN: day 31, month 01, year 23, cursor at month, up -> month 8'h02, day 8'h28; year set to 24, day up from 28 -> 8'h29, then -> 8'h01.

Source files
------------

// File: rtl/date_programmer_if.sv
// date_programmer_if: RTC date in, displayed date/cursor out,
// and the wr_req/wr_ack handshake toward the RTC write controller.
interface date_programmer_if;
  logic [7:0] rtc_day;
  logic [7:0] rtc_month;
  logic [7:0] rtc_year;
  logic       wr_ack;
  logic [7:0] fecha_out1;
  logic [7:0] fecha_out2;
  logic [7:0] fecha_out3;
  logic [3:0] direccion_actual_pantalla;
  logic       wr_req;

  modport master (
    input  rtc_day,
    input  rtc_month,
    input  rtc_year,
    input  wr_ack,
    output fecha_out1,
    output fecha_out2,
    output fecha_out3,
    output direccion_actual_pantalla,
    output wr_req
  );

  modport slave (
    output rtc_day,
    output rtc_month,
    output rtc_year,
    output wr_ack,
    input  fecha_out1,
    input  fecha_out2,
    input  fecha_out3,
    input  direccion_actual_pantalla,
    input  wr_req
  );
endinterface

// File: rtl/date_programmer.sv
// date_programmer: mirrors the RTC date, edits it from buttons, commits it.
// Optional macro DATE_PROG_MONTH_DAYS_EN: month/leap-aware day bound.
module date_programmer #(
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic programar_on,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  date_programmer_if.master bus
);

  localparam int CW =
    (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] RLAST = CW'(REPEAT_CYCLES - 1);

  localparam logic [3:0] CUR_NONE = 4'd0;
  localparam logic [3:0] CUR_DAY  = 4'd3;
  localparam logic [3:0] CUR_MON  = 4'd4;
  localparam logic [3:0] CUR_YR   = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } state_t;

  state_t     state_q;
  logic [7:0] day_q, mon_q, yr_q;
  logic [3:0] cur_q;
  logic       wr_req_q;

  logic [7:0] day_e, day_d, mon_d, yr_d;
  logic [3:0] cur_d;
  logic [7:0] hi_now, snap_day;

  // bit order: up, down, left, right
  logic [3:0]    raw;
  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    prev_q;
  logic [CW-1:0] cnt_q [4];
  logic [3:0]    lvl, pulse;
  logic          inc, dec, mv_r, mv_l;

  assign raw = {btn_up, btn_down, btn_left, btn_right};
  assign lvl = sync_q[SYNC_STAGES-1];

  function automatic logic [7:0] bcd_up(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (v >= hi) return lo;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dn(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (v <= lo) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'h9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

`ifdef DATE_PROG_MONTH_DAYS_EN
  logic [7:0] hi_new, hi_snap;

  // Leap years in BCD: tens even with units 0/4/8, tens odd with 2/6.
  function automatic logic [7:0] day_max(
    input logic [7:0] m,
    input logic [7:0] y
  );
    logic leap;
    leap = y[4] ? (y[3:0] == 4'd2 || y[3:0] == 4'd6)
                : (y[3:0] == 4'd0 || y[3:0] == 4'd4 ||
                   y[3:0] == 4'd8);
    if (m == 8'h02) return leap ? 8'h29 : 8'h28;
    if (m == 8'h04 || m == 8'h06 ||
        m == 8'h09 || m == 8'h11) return 8'h30;
    return 8'h31;
  endfunction

  assign hi_now   = day_max(mon_q, yr_q);
  assign hi_new   = day_max(mon_d, yr_d);
  assign hi_snap  = day_max(bus.rtc_month, bus.rtc_year);
  assign snap_day = (bus.rtc_day > hi_snap) ? hi_snap
                                            : bus.rtc_day;
  assign day_d    = (day_e > hi_new) ? hi_new : day_e;
`else
  assign hi_now   = 8'h31;
  assign snap_day = bus.rtc_day;
  assign day_d    = day_e;
`endif

  // Synchronize buttons and time the hold for auto-repeat
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= lvl;
      for (int b = 0; b < 4; b++) begin
        if (!lvl[b] || cnt_q[b] == RLAST) cnt_q[b] <= '0;
        else cnt_q[b] <= cnt_q[b] + 1'b1;
      end
    end
  end

  // One pulse on the rising edge, one more each repeat period
  always_comb begin
    pulse = '0;
    for (int b = 0; b < 4; b++)
      pulse[b] = lvl[b] & (~prev_q[b] | (cnt_q[b] == RLAST));
  end

  assign inc  = pulse[3] & ~pulse[2];
  assign dec  = pulse[2] & ~pulse[3];
  assign mv_l = pulse[1] & ~pulse[0];
  assign mv_r = pulse[0] & ~pulse[1];

  // Edit the field under the old cursor and move the cursor
  always_comb begin
    day_e = day_q;
    mon_d = mon_q;
    yr_d  = yr_q;
    cur_d = cur_q;
    unique case (1'b1)
      inc && cur_q == CUR_DAY: day_e = bcd_up(day_q, 8'h01, hi_now);
      dec && cur_q == CUR_DAY: day_e = bcd_dn(day_q, 8'h01, hi_now);
      inc && cur_q == CUR_MON: mon_d = bcd_up(mon_q, 8'h01, 8'h12);
      dec && cur_q == CUR_MON: mon_d = bcd_dn(mon_q, 8'h01, 8'h12);
      inc && cur_q == CUR_YR:  yr_d  = bcd_up(yr_q, 8'h00, 8'h99);
      dec && cur_q == CUR_YR:  yr_d  = bcd_dn(yr_q, 8'h00, 8'h99);
      default: ;
    endcase
    unique case (1'b1)
      mv_r: cur_d = (cur_q == CUR_YR) ? CUR_DAY : cur_q + 4'd1;
      mv_l: cur_d = (cur_q == CUR_DAY) ? CUR_YR : cur_q - 4'd1;
      default: ;
    endcase
  end

  // Mode FSM: mirror, edit, then hold the date until acknowledged
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      day_q    <= 8'h01;
      mon_q    <= 8'h01;
      yr_q     <= 8'h00;
      cur_q    <= CUR_NONE;
      wr_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          day_q <= programar_on ? snap_day : bus.rtc_day;
          mon_q <= bus.rtc_month;
          yr_q  <= bus.rtc_year;
          cur_q <= CUR_NONE;
          if (programar_on) begin
            state_q <= EDIT;
            cur_q   <= CUR_DAY;
          end
        end
        EDIT: begin
          day_q <= day_d;
          mon_q <= mon_d;
          yr_q  <= yr_d;
          cur_q <= cur_d;
          if (!programar_on) begin
            state_q  <= COMMIT;
            wr_req_q <= 1'b1;
            cur_q    <= CUR_NONE;
          end
        end
        COMMIT: begin
          if (bus.wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          wr_req_q <= 1'b0;
          cur_q    <= CUR_NONE;
        end
      endcase
    end
  end

  assign bus.fecha_out1 = day_q;
  assign bus.fecha_out2 = mon_q;
  assign bus.fecha_out3 = yr_q;
  assign bus.direccion_actual_pantalla = cur_q;
  assign bus.wr_req = wr_req_q;

endmodule
